// File: rtl/wb_write_back_if.sv
// wb_write_back_if: the bus between the MEM stage and the write-back stage.
//   master : MEM-side producer/observer. It drives stall/flush and the
//            in_* instruction fields, and reads the register-file write
//            port, the bypass record, misaligned and retire_count.
//   slave  : the write-back stage itself.
interface wb_write_back_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  // MEM -> WB
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_RegWrite;
  logic [1:0]        in_MemtoReg;
  logic [2:0]        in_load_type;
  logic [1:0]        in_addr_low;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_data;
  logic [DATA_W-1:0] in_pc_plus8;
  logic [4:0]        in_write_register;

  // WB -> register file / ID stage
  logic              RegWrite;
  logic [5:0]        write_register;
  logic [DATA_W-1:0] write_data;
  logic              fwd_valid;
  logic [4:0]        fwd_register;
  logic [DATA_W-1:0] fwd_data;
  logic              misaligned;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output stall, flush, in_valid, in_RegWrite, in_MemtoReg, in_load_type,
           in_addr_low, in_alu_result, in_mem_data, in_pc_plus8,
           in_write_register,
    input  RegWrite, write_register, write_data, fwd_valid, fwd_register,
           fwd_data, misaligned, retire_count
  );

  modport slave (
    input  stall, flush, in_valid, in_RegWrite, in_MemtoReg, in_load_type,
           in_addr_low, in_alu_result, in_mem_data, in_pc_plus8,
           in_write_register,
    output RegWrite, write_register, write_data, fwd_valid, fwd_register,
           fwd_data, misaligned, retire_count
  );
endinterface

// File: rtl/wb_write_back.sv
// wb_write_back: write-back stage of the 5-stage MIPS pipeline.
//   Holds the MEM/WB pipeline register, extracts byte/half loads
//   (big-endian, sign or zero extended), selects ALU / load / link result,
//   and writes the register file exactly once per instruction.
//   Ports:
//     clk   - pipeline clock, rising edge
//     reset - asynchronous, active-high
//     wb    - wb_write_back_if.slave (stall/flush, in_* fields, register-file
//             write port, one-cycle bypass record, misaligned, retire_count)
module wb_write_back #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  wb_write_back_if.slave  wb
);

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;

  // MEM/WB pipeline register
  logic              valid;
  logic              done;      // instruction already wrote/retired while stalled
  logic              r_regwrite;
  logic [1:0]        r_memtoreg;
  logic [2:0]        r_load_type;
  logic [1:0]        r_addr_low;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] r_pc_plus8;
  logic [4:0]        r_dest;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] result;
  logic              mis_raw;
  logic              active;
  logic              commit;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the datapath fields are reset too, so write_register and the
    // other field-derived outputs read 0 the instant reset asserts.
    if (reset) begin
      valid        <= 1'b0;
      done         <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= '0;
      r_load_type  <= '0;
      r_addr_low   <= '0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_pc_plus8   <= '0;
      r_dest       <= '0;
    end else if (wb.flush) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, regardless of statement order.
      valid <= 1'b0;
    end else if (!wb.stall) begin
      valid        <= wb.in_valid;
      done         <= 1'b0;
      r_regwrite   <= wb.in_RegWrite;
      r_memtoreg   <= wb.in_MemtoReg;
      r_load_type  <= wb.in_load_type;
      r_addr_low   <= wb.in_addr_low;
      r_alu_result <= wb.in_alu_result;
      r_mem_data   <= wb.in_mem_data;
      r_pc_plus8   <= wb.in_pc_plus8;
      r_dest       <= wb.in_write_register;
    end else if (active) begin
      // Stalled: the first cycle in the stage already wrote and retired.
      done <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no
    // path through the case statements can infer a latch.
    ld_byte  = r_mem_data[DATA_W-1 -: 8];
    ld_half  = r_mem_data[DATA_W-1 -: 16];
    load_val = r_mem_data;
    mis_raw  = 1'b0;
    result   = r_alu_result;

    // Big-endian: address byte 0 is the most significant byte of the word.
    case (r_addr_low)
      2'd1:    ld_byte = r_mem_data[DATA_W-9  -: 8];
      2'd2:    ld_byte = r_mem_data[DATA_W-17 -: 8];
      2'd3:    ld_byte = r_mem_data[DATA_W-25 -: 8];
      default: ld_byte = r_mem_data[DATA_W-1  -: 8];
    endcase
    if (r_addr_low[1]) ld_half = r_mem_data[DATA_W-17 -: 16];

    case (r_load_type)
      LT_LB:   load_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LT_LBU:  load_val = {{(DATA_W-8){1'b0}}, ld_byte};
      LT_LH:   load_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LT_LHU:  load_val = {{(DATA_W-16){1'b0}}, ld_half};
      default: load_val = r_mem_data;
    endcase

    // Alignment only means something for a load; ALU/link results leave
    // load_type/addr_low as don't-cares.
    if (r_memtoreg == MTR_MEM) begin
      case (r_load_type)
        LT_LB, LT_LBU: mis_raw = 1'b0;
        LT_LH, LT_LHU: mis_raw = r_addr_low[0];
        default:       mis_raw = (r_addr_low != 2'd0);
      endcase
    end

    case (r_memtoreg)
      MTR_MEM:  result = load_val;
      MTR_LINK: result = r_pc_plus8;
      default:  result = r_alu_result;
    endcase
  end

  assign active = valid & ~done;
  assign commit = active & r_regwrite & (r_dest != 5'd0) & ~mis_raw;

  assign wb.RegWrite       = commit;
  assign wb.write_register = {1'b0, r_dest};
  assign wb.write_data     = valid ? result : '0;
  assign wb.misaligned     = active & mis_raw;

  // Bypass record covers the register file's write-then-read edge; retire
  // counter ticks once per instruction, on its first cycle in the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb.fwd_valid    <= 1'b0;
      wb.fwd_register <= '0;
      wb.fwd_data     <= '0;
      wb.retire_count <= '0;
    end else begin
      wb.fwd_valid <= commit;
      if (commit) begin
        wb.fwd_register <= r_dest;
        wb.fwd_data     <= result;
      end
      if (active) wb.retire_count <= wb.retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_write_back.sv
// tb_wb_write_back: directed-vector bench for wb_write_back.
//   Inputs are driven 1 ns after a rising edge; outputs are checked there too,
//   so every sample is well away from the active edge.
module tb_wb_write_back;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   exp_ret;
  int   rw_hi;

  wb_write_back_if #(.DATA_W(32), .CNT_W(32)) bus ();

  wb_write_back #(.DATA_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not terminate");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [1:0] mtr,
                       input logic [2:0] lt, input logic [1:0] al,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input logic [4:0] dest);
    bus.in_valid          = 1'b1;
    bus.in_RegWrite       = rw;
    bus.in_MemtoReg       = mtr;
    bus.in_load_type      = lt;
    bus.in_addr_low       = al;
    bus.in_alu_result     = alu;
    bus.in_mem_data       = mem;
    bus.in_pc_plus8       = pc;
    bus.in_write_register = dest;
  endtask

  task automatic bubble();
    issue(1'b0, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".RegWrite"},       64'(bus.RegWrite),       64'd0);
    check({tag, ".write_register"}, 64'(bus.write_register), 64'd0);
    check({tag, ".write_data"},     64'(bus.write_data),     64'd0);
    check({tag, ".fwd_valid"},      64'(bus.fwd_valid),      64'd0);
    check({tag, ".fwd_register"},   64'(bus.fwd_register),   64'd0);
    check({tag, ".fwd_data"},       64'(bus.fwd_data),       64'd0);
    check({tag, ".misaligned"},     64'(bus.misaligned),     64'd0);
    check({tag, ".retire_count"},   64'(bus.retire_count),   64'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_ret = 0;
    reset   = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bubble();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    step();

    // ALU op to r8: written on the next cycle, bypassed the cycle after.
    issue(1'b1, 2'b00, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd8);
    step();
    check("alu.RegWrite",       64'(bus.RegWrite),       64'd1);
    check("alu.write_register", 64'(bus.write_register), 64'd8);
    check("alu.write_data",     64'(bus.write_data),     64'h1234_5678);
    check("alu.retire_before",  64'(bus.retire_count),   64'd0);
    bubble();
    step();
    exp_ret++;
    check("alu.fwd_valid",      64'(bus.fwd_valid),      64'd1);
    check("alu.fwd_register",   64'(bus.fwd_register),   64'd8);
    check("alu.fwd_data",       64'(bus.fwd_data),       64'h1234_5678);
    check("alu.retire",         64'(bus.retire_count),   64'(exp_ret));
    check("bubble.RegWrite",    64'(bus.RegWrite),       64'd0);
    check("bubble.write_data",  64'(bus.write_data),     64'd0);

    // Loads from word 0x0080FF00 (bytes 00 80 FF 00 big-endian).
    issue(1'b1, 2'b01, 3'd1, 2'd1, 32'h0, 32'h0080_FF00, 32'h0, 5'd3); // lb
    step();
    check("lb.write_data",  64'(bus.write_data), 64'hFFFF_FF80);
    check("lb.RegWrite",    64'(bus.RegWrite),   64'd1);
    check("lb.misaligned",  64'(bus.misaligned), 64'd0);
    issue(1'b1, 2'b01, 3'd2, 2'd1, 32'h0, 32'h0080_FF00, 32'h0, 5'd3); // lbu
    step();
    exp_ret++;
    check("lbu.write_data", 64'(bus.write_data), 64'h0000_0080);
    check("lb.fwd_data",    64'(bus.fwd_data),   64'hFFFF_FF80);
    issue(1'b1, 2'b01, 3'd4, 2'd2, 32'h0, 32'h0080_FF00, 32'h0, 5'd3); // lhu
    step();
    exp_ret++;
    check("lhu.write_data", 64'(bus.write_data), 64'h0000_FF00);
    issue(1'b1, 2'b01, 3'd3, 2'd0, 32'h0, 32'h0080_FF00, 32'h0, 5'd3); // lh
    step();
    exp_ret++;
    check("lh.write_data",  64'(bus.write_data), 64'h0000_0080);
    check("loads.retire",   64'(bus.retire_count), 64'(exp_ret));

    // jal: link address to r31.
    issue(1'b1, 2'b10, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0040_0010, 5'd31);
    step();
    exp_ret++;
    check("jal.write_data",     64'(bus.write_data),     64'h0040_0010);
    check("jal.RegWrite",       64'(bus.RegWrite),       64'd1);
    check("jal.write_register", 64'(bus.write_register), 64'd31);
    bubble();
    step();
    exp_ret++;
    check("jal.fwd_register",   64'(bus.fwd_register),   64'd31);
    check("jal.fwd_data",       64'(bus.fwd_data),       64'h0040_0010);
    check("jal.retire",         64'(bus.retire_count),   64'(exp_ret));

    // add to r5 held for 3 stalled cycles: one write, one retire.
    issue(1'b1, 2'b00, 3'd0, 2'd0, 32'h0000_A5A5, 32'h0, 32'h0, 5'd5);
    step();
    check("stall.first_RegWrite", 64'(bus.RegWrite), 64'd1);
    bus.stall = 1'b1;
    issue(1'b1, 2'b00, 3'd0, 2'd0, 32'h0000_1111, 32'h0, 32'h0, 5'd9);
    rw_hi = 0;
    step();
    exp_ret++;
    rw_hi += int'(bus.RegWrite);
    check("stall.fwd_valid_first", 64'(bus.fwd_valid), 64'd1);
    repeat (2) begin
      step();
      rw_hi += int'(bus.RegWrite);
    end
    check("stall.extra_writes",   64'(rw_hi),              64'd0);
    check("stall.fwd_valid_held", 64'(bus.fwd_valid),      64'd0);
    check("stall.write_register", 64'(bus.write_register), 64'd5);
    check("stall.write_data",     64'(bus.write_data),     64'h0000_A5A5);
    check("stall.retire",         64'(bus.retire_count),   64'(exp_ret));
    bus.stall = 1'b0;
    bubble();
    step();
    check("stall.release_retire", 64'(bus.retire_count),   64'(exp_ret));

    // Misaligned lh and lw: no write, still retire.
    issue(1'b1, 2'b01, 3'd3, 2'd1, 32'h0, 32'h1234_5678, 32'h0, 5'd4);
    step();
    check("lh_mis.misaligned", 64'(bus.misaligned), 64'd1);
    check("lh_mis.RegWrite",   64'(bus.RegWrite),   64'd0);
    issue(1'b1, 2'b01, 3'd0, 2'd2, 32'h0, 32'h1234_5678, 32'h0, 5'd4);
    step();
    exp_ret++;
    check("lw_mis.misaligned", 64'(bus.misaligned),   64'd1);
    check("lw_mis.RegWrite",   64'(bus.RegWrite),     64'd0);
    check("lh_mis.fwd_valid",  64'(bus.fwd_valid),    64'd0);
    check("lh_mis.retire",     64'(bus.retire_count), 64'(exp_ret));

    // Destination r0: never written, never bypassed, still retires.
    issue(1'b1, 2'b00, 3'd0, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 5'd0);
    step();
    exp_ret++;
    check("r0.RegWrite",   64'(bus.RegWrite),   64'd0);
    check("r0.misaligned", 64'(bus.misaligned), 64'd0);
    bubble();
    step();
    exp_ret++;
    check("r0.fwd_valid",  64'(bus.fwd_valid),    64'd0);
    check("r0.retire",     64'(bus.retire_count), 64'(exp_ret));

    // Flush+stall drops the held instruction, then blocks a new capture.
    issue(1'b1, 2'b00, 3'd0, 2'd0, 32'h0000_CAFE, 32'h0, 32'h0, 5'd7);
    step();
    check("flush.pre_RegWrite", 64'(bus.RegWrite), 64'd1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    issue(1'b1, 2'b00, 3'd0, 2'd0, 32'h0000_BEEF, 32'h0, 32'h0, 5'd10);
    step();
    exp_ret++;
    check("flush.RegWrite",   64'(bus.RegWrite),     64'd0);
    check("flush.write_data", 64'(bus.write_data),   64'd0);
    check("flush.retire",     64'(bus.retire_count), 64'(exp_ret));
    step();
    check("flush_cap.RegWrite", 64'(bus.RegWrite),     64'd0);
    check("flush_cap.fwd_valid", 64'(bus.fwd_valid),   64'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bubble();
    step();
    check("flush_cap.retire",   64'(bus.retire_count), 64'(exp_ret));

    // Async reset mid-stall: everything reads 0 before the next edge.
    issue(1'b1, 2'b00, 3'd0, 2'd0, 32'h0000_0055, 32'h0, 32'h0, 5'd12);
    step();
    bus.stall = 1'b1;
    step();
    exp_ret++;
    check("prereset.fwd_valid", 64'(bus.fwd_valid),    64'd1);
    check("prereset.retire",    64'(bus.retire_count), 64'(exp_ret));
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    bus.stall = 1'b0;
    bubble();
    step();
    check("postreset.retire",   64'(bus.retire_count), 64'd0);
    check("postreset.RegWrite", 64'(bus.RegWrite),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_write_back.md
Name: wb_write_back

Overview:
- Write-back stage of the 5-stage MIPS pipeline; the writer side of the ID-stage register file.
- Holds the MEM/WB pipeline register and selects the result: ALU, load data or link address.
- Performs load byte/half extraction with sign or zero extension.
- Drives RegWrite/write_register/write_data into the register file exactly once per instruction.
- Provides a one-cycle bypass record covering the register file's write-then-read edge, plus a retire counter.

Parameters:
- DATA_W, 32, datapath width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold MEM/WB register contents.
- flush  in  1  invalidate MEM/WB register; wins over stall.
- in_valid  in  1  MEM stage presents a real instruction.
- in_RegWrite  in  1  instruction writes a register.
- in_MemtoReg  in  2  00 ALU, 01 memory, 10 link (PC+8), 11 reserved (treated as ALU).
- in_load_type  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others behave as lw.
- in_addr_low  in  2  address bits [1:0] of the load.
- in_alu_result  in  32  ALU result.
- in_mem_data  in  32  aligned memory word.
- in_pc_plus8  in  32  link address.
- in_write_register  in  5  destination register number.
- RegWrite  out  1  register file write enable.
- write_register  out  6  destination; bit 5 is always 0.
- write_data  out  32  value to write.
- fwd_valid  out  1  bypass record valid.
- fwd_register  out  5  bypass destination.
- fwd_data  out  32  bypass value.
- misaligned  out  1  lh/lhu with in_addr_low[0]=1, or lw with in_addr_low!=0.
- retire_count  out  CNT_W  number of instructions retired.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - Clears the stage valid bit, done flag, bypass record and retire_count.
  - All outputs read 0 from the moment reset asserts.
- Capture on each rising edge, in priority order:
  - flush: valid<=0.
  - else !stall: capture all in_* fields; valid<=in_valid; done<=0.
  - else (stall): fields hold.
- Write window:
  - commit = valid & !done & stored RegWrite & (dest != 0) & !misaligned.
  - RegWrite = commit.
  - Any cycle with valid & !done sets done<=1 on the next edge, unless a new capture occurs on that edge.
  - Result: a stalled instruction writes and retires exactly once, in its first cycle in the stage.
- Latency: an instruction captured at edge N is written to the register file at edge N+1.
- Result mux:
  - 00/11: alu_result.
  - 10: pc_plus8.
  - 01: extracted load data.
- Load extraction (big-endian):
  - Bytes: addr_low 0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
  - Halves: addr_low[1]=0 selects [31:16], 1 selects [15:0].
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
  - Misaligned loads: write suppressed, misaligned=1 combinationally while valid & !done, instruction still retires.
- write_register = {1'b0, dest}.
- write_data is the mux output whenever valid, else 0.
- Bypass record:
  - Any edge where commit=1 loads fwd_register/fwd_data and sets fwd_valid<=1.
  - Otherwise fwd_valid<=0; register and data hold.
  - The ID stage uses it to read the value written on the previous edge.
- retire_count:
  - Increments by 1 on each edge where valid & !done.
  - Wraps modulo 2^CNT_W.
  - Flushed or bubble cycles do not count.
- Simultaneous flush and stall: flush wins and the held instruction is dropped. If it had not yet committed, no write occurs.
- Destination register 0: never asserts RegWrite and never loads the bypass record, but still retires.

Test Plan:
- Reset then ALU op: alu_result=0x1234_5678, dest=8, RegWrite path -> next cycle RegWrite=1, write_register=6'd8, write_data=0x12345678. Following cycle fwd_valid=1, fwd_data=0x12345678, retire_count=1.
- lb, addr_low=1, mem_data=0x00_80_FF_00 -> write_data=0xFFFFFF80. lbu, same inputs -> 0x00000080. lhu, addr_low=2 -> 0x0000FF00.
- jal: MemtoReg=10, pc_plus8=0x0040_0010, dest=31 -> write_data=0x00400010, RegWrite=1.
- Stall held 3 cycles on an add to dest=5 -> RegWrite high for exactly 1 cycle, retire_count +1 only.
- lh with addr_low=1 -> misaligned=1, RegWrite=0, retire_count +1. Dest=0 ALU op -> RegWrite=0, fwd_valid stays 0.
- Flush and stall asserted together while an instruction is captured -> no write. Async reset mid-stream -> all outputs 0 immediately, retire_count=0.
